vc_sa_req_tracker: RTL

VC_SA_REQ_TRACKER -- requirements
Module: vc_sa_req_tracker

---
 rtl/vc_router_pkg.sv | 20 ++
 rtl/rr_vc_select.sv | 61 ++++++
 rtl/vc_sa_req_tracker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vc_router_pkg.sv
// rtl/vc_router_pkg.sv - shared types and width helpers for the VC switch-allocation request tracker
//   vc_state_e    : per input VC binding state (IDLE, ACTIVE)
//   idx_width()   : bits needed to index n entries (at least 1)
//   credit_width(): bits needed to count 0..depth
package vc_router_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_vc_select.sv
// rtl/rr_vc_select.sv - round-robin pick of one requesting VC within an input port
//   clk, rst_n : clock, synchronous active-low reset
//   req        : [NUM_VC] ready VCs of this port
//   advance    : the presented selection was granted this cycle
//   adv_sel    : [NUM_VC] one-hot selection that was granted
//   gnt        : [NUM_VC] one-hot pick (zero when no request)
module rr_vc_select
  import vc_router_pkg::*;
#(
  parameter int NUM_VC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_VC-1:0] req,
  input  logic              advance,
  input  logic [NUM_VC-1:0] adv_sel,
  output logic [NUM_VC-1:0] gnt
);

  localparam int PW = idx_width(NUM_VC);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  // Scan from the pointer position, wrapping, and take the first request.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_VC; k++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (!found && req[v] && (v == ((int'(ptr_q) + k) % NUM_VC))) begin
          gnt[v] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  // The pointer follows the granted selection, which in the registered
  // build is not the same as the current combinational pick.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (adv_sel[v]) begin
          ptr_d = PW'((v + 1) % NUM_VC);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vc_sa_req_tracker.sv
// rtl/vc_sa_req_tracker.sv - tracks VC bindings and credits, raises per-port switch allocation requests
//   clk, rst_n    : clock, synchronous active-low reset
//   vc_grants     : [N][N] row i one-hot new binding of input VC i to output VC j
//   flit_valid    : [N] input VC buffer non-empty
//   flit_is_tail  : [N] head flit of input VC is a tail
//   sa_grant      : [NUM_PORTS] input port's presented request won switch allocation
//   credit_return : [N] one credit back for output VC j
//   port_req      : [NUM_PORTS][NUM_PORTS] one-hot requested output port per input port
//   sel_vc        : [NUM_PORTS][NUM_VC] one-hot VC behind port_req
//   err           : sticky protocol error
//   Macro VC_SA_REQ_REG_EN: register port_req/sel_vc (one-cycle latency).
module vc_sa_req_tracker
  import vc_router_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_VC    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_PORTS*NUM_VC-1:0][NUM_PORTS*NUM_VC-1:0] vc_grants,
  input  logic [NUM_PORTS*NUM_VC-1:0]                    flit_valid,
  input  logic [NUM_PORTS*NUM_VC-1:0]                    flit_is_tail,
  input  logic [NUM_PORTS-1:0]                           sa_grant,
  input  logic [NUM_PORTS*NUM_VC-1:0]                    credit_return,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]            port_req,
  output logic [NUM_PORTS-1:0][NUM_VC-1:0]               sel_vc,
  output logic                                           err
);

  localparam int N  = NUM_PORTS * NUM_VC;
  localparam int IW = idx_width(N);
  localparam int CW = credit_width(BUF_DEPTH);

  vc_state_e     state_q  [N];
  vc_state_e     state_d  [N];
  logic [IW-1:0] bound_q  [N];
  logic [IW-1:0] bound_d  [N];
  logic [CW-1:0] credit_q [N];
  logic [CW-1:0] credit_d [N];
  logic          err_q;
  logic          err_d;

  logic [N-1:0]                          ready;
  logic [N-1:0]                          sent;
  logic [N-1:0]                          dec;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]      sel_c;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]      sel_eff;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   req_c;
  logic [NUM_PORTS-1:0]                  gacc;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ready[i] = (state_q[i] == ACTIVE) && flit_valid[i] && (credit_q[bound_q[i]] != '0);
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rr_vc_select #(
      .NUM_VC (NUM_VC)
    ) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (ready[p*NUM_VC +: NUM_VC]),
      .advance (gacc[p]),
      .adv_sel (sel_eff[p]),
      .gnt     (sel_c[p])
    );
  end

  // Output port of the picked VC is its bound output VC divided by NUM_VC.
  always_comb begin
    req_c = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        for (int q = 0; q < NUM_PORTS; q++) begin
          if (sel_c[p][v] && ((int'(bound_q[p*NUM_VC+v]) / NUM_VC) == q)) begin
            req_c[p][q] = 1'b1;
          end
        end
      end
    end
  end

`ifdef VC_SA_REQ_REG_EN
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] port_req_q;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]    sel_vc_q;

  // A granted port shows nothing next cycle: the registered pick would be
  // stale relative to the credit/state update the grant just caused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_req_q <= '0;
      sel_vc_q   <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_req_q[p] <= gacc[p] ? '0 : req_c[p];
        sel_vc_q[p]   <= gacc[p] ? '0 : sel_c[p];
      end
    end
  end

  assign sel_eff  = sel_vc_q;
  assign port_req = port_req_q;
  assign sel_vc   = sel_vc_q;
`else
  assign sel_eff  = sel_c;
  assign port_req = req_c;
  assign sel_vc   = sel_c;
`endif

  // A grant only counts against a non-empty presented selection.
  always_comb begin
    sent = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gacc[p] = sa_grant[p] && (sel_eff[p] != '0);
      for (int v = 0; v < NUM_VC; v++) begin
        sent[p*NUM_VC+v] = gacc[p] && sel_eff[p][v];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      dec[j] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (sent[i] && (bound_q[i] == IW'(j))) begin
          dec[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < N; i++) begin
      logic [N-1:0]  g;
      logic          g_nz;
      logic          g_one;
      logic [IW-1:0] g_idx;
      logic          tail_sent;
      g         = vc_grants[i];
      g_nz      = (g != '0);
      g_one     = ($countones(g) == 1);
      g_idx     = '0;
      tail_sent = sent[i] && flit_is_tail[i];
      for (int j = 0; j < N; j++) begin
        if (g[j]) begin
          g_idx = IW'(j);
        end
      end
      state_d[i] = state_q[i];
      bound_d[i] = bound_q[i];
      if (state_q[i] == IDLE) begin
        if (g_one) begin
          state_d[i] = ACTIVE;
          bound_d[i] = g_idx;
        end else if (g_nz) begin
          err_d = 1'b1;
        end
      end else if (tail_sent) begin
        // Tail leaves this cycle; a clean grant rebinds without passing IDLE.
        if (g_one) begin
          bound_d[i] = g_idx;
        end else begin
          state_d[i] = IDLE;
          if (g_nz) begin
            err_d = 1'b1;
          end
        end
      end else if (g_nz) begin
        err_d = 1'b1;
      end
    end

    for (int j = 0; j < N; j++) begin
      credit_d[j] = credit_q[j];
      if (dec[j] && !credit_return[j]) begin
        if (credit_q[j] != '0) begin
          credit_d[j] = credit_q[j] - CW'(1);
        end
      end else if (credit_return[j] && !dec[j]) begin
        if (credit_q[j] == CW'(BUF_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          credit_d[j] = credit_q[j] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i]  <= IDLE;
        bound_q[i]  <= '0;
        credit_q[i] <= CW'(BUF_DEPTH);
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i]  <= state_d[i];
        bound_q[i]  <= bound_d[i];
        credit_q[i] <= credit_d[i];
      end
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule
